// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: slice op codes, FSM state
// encoding and the bit-counter width helper.
package serial_alu_pkg;

    localparam logic [2:0] OP_AND  = 3'd7;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_RSV1 = 3'd1;
    localparam logic [2:0] OP_RSV0 = 3'd0;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu1.sv
// One-bit ALU slice driven by serial_alu_seq. For SUB, carry_in/carry_out carry
// a borrow; reserved selects return 0 on both outputs.
module alu1
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [2:0] select,
    output logic       out,
    output logic       carry_out
);

    always_comb begin
        out       = 1'b0;
        carry_out = 1'b0;
        case (select)
            OP_AND: out = a & b;
            OP_NOT: out = ~a;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
            OP_ADD: begin
                out       = a ^ b ^ carry_in;
                carry_out = (a & b) | (a & carry_in) | (b & carry_in);
            end
            OP_SUB: begin
                out       = a ^ b ^ carry_in;
                carry_out = (~a & b) | (~a & carry_in) | (b & carry_in);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_alu_shreg.sv
// WIDTH-bit register with synchronous clear, parallel load and right shift with
// serial input at the MSB. Clear beats load, load beats shift.
module serial_alu_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_shift,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= {i_sin, r_q[WIDTH-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer driving an external alu1 slice LSB-first.
// Optional flag outputs result_zero/result_ovf are built when SERIAL_ALU_FLAGS_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a request, start_ready high
// RUN     | one operand bit per cycle through the slice
// DONE    | result held until result_ready
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_carry_in,
    output logic [2:0]       slice_select,
    input  logic             slice_out,
    input  logic             slice_carry_out,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_carry
`ifdef SERIAL_ALU_FLAGS_EN
   ,output logic             result_zero,
    output logic             result_ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_carry;

    logic              w_live;
    logic              w_idle;
    logic              w_run;
    logic              w_done;
    logic              w_accept;
    logic              w_last;
    logic              w_addsub;
    logic [WIDTH-1:0]  w_a_q;
    logic [WIDTH-1:0]  w_b_q;
    logic [WIDTH-1:0]  w_res_q;
    logic              w_unused;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_run    = (r_state == ST_RUN);
    assign w_done   = (r_state == ST_DONE);
    assign w_accept = w_idle && start_valid;
    assign w_last   = w_run && (r_cnt == CNT_LAST);
    assign w_addsub = (r_op == OP_ADD) || (r_op == OP_SUB);
    // Outputs are forced quiet while rst is high so nothing leaks out of an aborted op.
    assign w_live   = ~rst;

    serial_alu_shreg #(.WIDTH(WIDTH)) u_a_sr (
        .clk        (clk),
        .i_clr      (rst),
        .i_load     (w_accept),
        .i_load_val (a_in),
        .i_shift    (w_run),
        .i_sin      (1'b0),
        .o_q        (w_a_q)
    );

    serial_alu_shreg #(.WIDTH(WIDTH)) u_b_sr (
        .clk        (clk),
        .i_clr      (rst),
        .i_load     (w_accept),
        .i_load_val (b_in),
        .i_shift    (w_run),
        .i_sin      (1'b0),
        .o_q        (w_b_q)
    );

    serial_alu_shreg #(.WIDTH(WIDTH)) u_res_sr (
        .clk        (clk),
        .i_clr      (rst),
        .i_load     (w_accept),
        .i_load_val ({WIDTH{1'b0}}),
        .i_shift    (w_run),
        .i_sin      (slice_out),
        .o_q        (w_res_q)
    );

    // Only the LSB of each operand register is ever presented to the slice.
    assign w_unused = ^{w_a_q[WIDTH-1:1], w_b_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'd0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_op    <= op;
                        r_carry <= cin_in;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_carry <= slice_carry_out;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign start_ready    = w_live && w_idle;
    assign slice_a        = w_live && w_run && w_a_q[0];
    assign slice_b        = w_live && w_run && w_b_q[0];
    assign slice_carry_in = w_live && w_run && r_carry;
    assign slice_select   = (w_live && w_run) ? r_op : 3'd0;
    assign result_valid   = w_live && w_done;
    assign result         = (w_live && w_done) ? w_res_q : {WIDTH{1'b0}};
    assign result_carry   = w_live && w_done && w_addsub && r_carry;

`ifdef SERIAL_ALU_FLAGS_EN
    // Carry into the MSB, captured while the last bit is in the slice.
    logic r_carry_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry_msb <= 1'b0;
        end else if (w_last) begin
            r_carry_msb <= r_carry;
        end
    end

    assign result_zero = w_live && w_done && (w_res_q == {WIDTH{1'b0}});
    assign result_ovf  = w_live && w_done && w_addsub && (r_carry_msb ^ r_carry);
`endif

endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial sequencer sitting directly upstream of the 1-bit ALU slice (alu1). Accepts a WIDTH-bit operation over a valid/ready handshake, then drives the slice LSB-first, one bit per cycle. It feeds the slice's carry/borrow output back as the next bit's carry-in, collects the slice output into a result shift register, and presents the result plus final carry over a second valid/ready handshake.

## Interface
- WIDTH, default 8: operand and result width, legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  request present.
- start_ready  output  1  sequencer can accept a request.
- op  input  3  slice select code; see package.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- cin_in  input  1  initial carry-in for ADD, or initial borrow-in for SUB.
- slice_a  output  1  to slice input a.
- slice_b  output  1  to slice input b.
- slice_carry_in  output  1  to slice input carry_in.
- slice_select  output  3  to slice input select.
- slice_out  input  1  from slice output out.
- slice_carry_out  input  1  from slice output carry_out.
- result_valid  output  1  result present.
- result_ready  input  1  consumer accepts the result.
- result  output  WIDTH  assembled result.
- result_carry  output  1  final carry (ADD) or borrow (SUB); 0 for all other ops.

## Operation
- Op codes: AND=7, NOT=6 (result is ~A), OR=5, XOR=4, ADD=3, SUB=2 (A−B−borrow). Codes 1 and 0 are reserved; the slice returns 0 for both, giving result 0 and carry 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE
  - start_ready=1.
  - On start_valid&&start_ready: load a_sr=a_in, b_sr=b_in, op_r=op, carry_r=cin_in, res_sr=0, cnt=0. Next state is RUN.
- RUN
  - Slice drive: slice_a=a_sr[0], slice_b=b_sr[0], slice_carry_in=carry_r, slice_select=op_r.
  - Each edge: a_sr and b_sr shift right; res_sr <= {slice_out, res_sr[WIDTH-1:1]}; carry_r <= slice_carry_out; cnt++.
  - On the edge where cnt==WIDTH-1, next state is DONE.
- DONE
  - result_valid=1; result=res_sr.
  - result_carry=carry_r when op_r is ADD or SUB, else 0.
  - result and result_carry are held stable until result_ready=1. On result_ready, next state is IDLE.
- Outside RUN, all slice_* outputs are 0. A select of 0 keeps the slice output at 0.
- start_ready is 0 in RUN and DONE. start_valid in those states is ignored and not queued.
- Carry chain width: carry_r is 1 bit; no extension. ADD 0xFF+0x01 wraps to 0x00 with result_carry=1.

## Timing
- Reset
  - While rst=1: state=IDLE and all registers clear.
  - Outputs during reset: start_ready=0, result_valid=0, result=0, result_carry=0, slice_*=0.
  - start_ready=1 from the first cycle after rst deasserts.
- Reset mid-RUN or mid-DONE aborts the operation immediately. The partial or pending result is discarded and result_valid never pulses.
- Latency: request accepted at edge E. Slice bit i is driven in the cycle after E+i. result_valid rises after edge E+WIDTH.
- Minimum initiation interval is WIDTH+2 cycles: WIDTH RUN cycles, at least one DONE cycle, one IDLE cycle.
- The slice path is combinational within one cycle: slice_out and slice_carry_out are sampled at the same edge that advances the bit.
- Back-pressure: DONE is held indefinitely while result_ready=0.

## Configuration
- SERIAL_ALU_FLAGS_EN defined: adds outputs result_zero (1 bit) and result_ovf (1 bit).
  - Both are valid with result_valid.
  - result_zero = (result==0).
  - result_ovf = (carry into MSB) XOR (carry out of MSB) for ADD/SUB, 0 otherwise.
  - Implementation: an extra register captures carry_r before the final bit.
- SERIAL_ALU_FLAGS_EN undefined: the ports and the register are absent. Behaviour is otherwise identical.

## Structure
- Package serial_alu_pkg holds:
  - op code localparams OP_AND, OP_NOT, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_RSV1, OP_RSV0;
  - the FSM state typedef (IDLE/RUN/DONE);
  - the counter width, computed as $clog2(WIDTH).
- One sub-module, serial_alu_shreg: WIDTH-bit register with parallel load, right shift with serial-in, and synchronous clear. It is instantiated three times (a_sr, b_sr, res_sr).
- The bench instantiates the alu1 slice alongside the sequencer and wires the slice_* ports to it.

## Test plan
All scenarios use WIDTH=8.
- ADD: a=0x7F, b=0x01, cin=0 -> result=0x80, result_carry=0, result_ovf=1, valid exactly 8 cycles after acceptance.
- SUB: a=0x05, b=0x07, borrow=0 -> result=0xFE, result_carry=1. Second case a=0x10, b=0x01, borrow=1 -> result=0x0E, result_carry=0.
- Logic ops:
  - AND 0xF0,0x3C -> 0x30.
  - OR -> 0xFC.
  - XOR -> 0xCC.
  - NOT a=0xA5 -> 0x5A.
  - Each with result_carry=0. Reserved op 1 -> 0x00.
- Back-pressure: hold result_ready=0 for 5 cycles -> result stable, start_ready=0, extra start_valid ignored. Then release -> one transfer, IDLE the next cycle.
- Reset asserted at bit 3 of an ADD -> no result_valid; the next request 0xFF+0x01 returns 0x00 with carry=1.
- Back-to-back requests with result_ready tied high -> initiation interval measured as exactly 10 cycles.
